// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a 4:1 single-bit mux channel with a per-owner hold limit.
// Ports: clk, rst_n, req[3:0], in[3:0], [lock if MUX4_RR_ARB_LOCK_EN] -> grant[3:0], s[1:0], out, busy.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] in,
`ifdef MUX4_RR_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] grant,
  output logic [1:0] s,
  output logic       out,
  output logic       busy
);

  typedef enum logic {IDLE, OWN} state_e;

  localparam logic [3:0] LIM = 4'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] s_q, s_d;
  logic       out_q, out_d;

  logic [1:0] own;
  logic       at_lim;
  logic       lock_own;
  logic [3:0] mask;
  logic [1:0] sptr;
  logic       fnd;
  logic [1:0] idx;

`ifdef MUX4_RR_ARB_LOCK_EN
  assign lock_own = lock;
`else
  assign lock_own = 1'b0;
`endif

  // s = 3-k, so the owner index is the bitwise inverse of s.
  assign own    = ~s_q;
  assign at_lim = (cnt_q == LIM);

  // Rescan source: from ptr in IDLE, from owner+1 on release,
  // with the owner masked out when the hold limit forced the release.
  always_comb begin
    mask = req;
    sptr = ptr_q;
    if (state_q == OWN) begin
      sptr = own + 2'd1;
      if (req[own]) mask[own] = 1'b0;
    end
  end

  always_comb begin
    fnd = 1'b0;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!fnd && mask[sptr + 2'(i)]) begin
        fnd = 1'b1;
        idx = sptr + 2'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    s_d     = s_q;
    unique case (state_q)
      IDLE: begin
        if (fnd) begin
          state_d = OWN;
          grant_d = 4'b0001 << idx;
          s_d     = ~idx;
          cnt_d   = 4'd0;
        end
      end
      OWN: begin
        if (req[own] && (!at_lim || lock_own)) begin
          if (!at_lim) cnt_d = cnt_q + 4'd1;
        end else begin
          ptr_d = own + 2'd1;
          cnt_d = 4'd0;
          if (fnd) begin
            grant_d = 4'b0001 << idx;
            s_d     = ~idx;
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
          end
        end
      end
    endcase
  end

  assign out_d = |(grant_q & in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      grant_q <= 4'b0000;
      s_q     <= 2'b00;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      s_q     <= s_d;
      out_q   <= out_d;
    end
  end

  assign grant = grant_q;
  assign s     = s_q;
  assign out   = out_q;
  assign busy  = |grant_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: stimulus pushes expected
// {grant,s,out,busy} per edge, a monitor pops and compares.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] in;
  logic       lock;
  logic [3:0] grant;
  logic [1:0] s;
  logic       out;
  logic       busy;

  typedef struct {
    int         id;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  mux4_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .in    (in),
`ifdef MUX4_RR_ARB_LOCK_EN
    .lock  (lock),
`endif
    .grant (grant),
    .s     (s),
    .out   (out),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int id,
                       input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else
      $display("FAIL %s #%0d: got g=%b s=%b o=%b b=%b, want g=%b s=%b o=%b b=%b",
               nm, id, act[7:4], act[3:2], act[1], act[0],
               exp[7:4], exp[3:2], exp[1], exp[0]);
  endtask

  function automatic logic [7:0] pk(input logic [3:0] g,
                                    input logic [1:0] sv,
                                    input logic o);
    return {g, sv, o, |g};
  endfunction

  // Drive one vector just before an edge and queue what must follow it.
  task automatic drive(input int id, input logic [3:0] r, input logic [3:0] d,
                       input logic l, input logic [3:0] g,
                       input logic [1:0] sv, input logic o);
    exp_t e;
    @(negedge clk);
    req  = r;
    in   = d;
    lock = l;
    e.id = id;
    e.v  = pk(g, sv, o);
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("edge", e.id, {grant, s, out, busy}, e.v);
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 5) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
      q.delete();
    end
  endtask

  logic [3:0] inr;
  int         own;
  int         prv;

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    in    = 4'b0000;
    lock  = 1'b0;
    #3;
    check("reset", 0, {grant, s, out, busy}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // single request, idle return, voluntary release with pending req[0]
    drive(1,  4'b0100, 4'b0100, 0, 4'b0100, 2'b01, 0);
    drive(2,  4'b0100, 4'b0100, 0, 4'b0100, 2'b01, 1);
    drive(3,  4'b0000, 4'b0100, 0, 4'b0000, 2'b01, 1);
    drive(4,  4'b0000, 4'b0100, 0, 4'b0000, 2'b01, 0);
    drive(5,  4'b0100, 4'b0000, 0, 4'b0100, 2'b01, 0);
    drive(6,  4'b0101, 4'b0000, 0, 4'b0100, 2'b01, 0);
    drive(7,  4'b0001, 4'b0001, 0, 4'b0001, 2'b11, 0);
    drive(8,  4'b0001, 4'b0001, 0, 4'b0001, 2'b11, 1);
    drive(9,  4'b0000, 4'b0001, 0, 4'b0000, 2'b11, 1);
    drive(10, 4'b0000, 4'b0001, 0, 4'b0000, 2'b11, 0);
    // ptr is now 1, so a full request goes to requester 1
    drive(11, 4'b1111, 4'b0000, 0, 4'b0010, 2'b10, 0);
    drain();

    // asynchronous reset mid-grant
    rst_n = 1'b0;
    #1;
    check("async_rst", 12, {grant, s, out, busy}, 8'h00);
    req = 4'b0000;
    in  = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // rotation 0,1,2,3,0 with four cycles each, starting from ptr=0
    inr = 4'b0101;
    for (int c = 0; c < 18; c++) begin
      own = (c / 4) % 4;
      prv = (c == 0) ? 0 : ((c - 1) / 4) % 4;
      drive(100 + c, 4'b1111, inr, 0, 4'b0001 << own, 2'(3 - own),
            (c == 0) ? 1'b0 : inr[prv]);
    end
    drain();

`ifdef MUX4_RR_ARB_LOCK_EN
    req = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(200, 4'b0010, 4'b0000, 1, 4'b0010, 2'b10, 0);
    for (int c = 1; c < 8; c++)
      drive(200 + c, 4'b1111, 4'b0000, 1, 4'b0010, 2'b10, 0);
    drive(208, 4'b1111, 4'b0000, 0, 4'b0100, 2'b01, 0);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
